// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and a small elaboration-time helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    function automatic int mdu_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for the MDU: signed/unsigned product and
// quotient/remainder packed as {hi, lo}, plus a divide-by-zero flag.
module mdu_arith #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);
    import mdu_pkg::*;

    logic               is_signed;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mag_prod;
    logic [WIDTH-1:0]   mag_quot;
    logic [WIDTH-1:0]   mag_rem;

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign is_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign a_neg     = is_signed && a[WIDTH-1];
    assign b_neg     = is_signed && b[WIDTH-1];

    // Work on magnitudes so one unsigned multiplier/divider serves both signed
    // and unsigned ops; most-negative / -1 falls out naturally as most-negative.
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign mag_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};

    always_comb begin
        mag_quot = '0;
        mag_rem  = '0;
        if (b_mag != '0) begin
            mag_quot = a_mag / b_mag;
            mag_rem  = a_mag % b_mag;
        end
    end

    always_comb begin
        div_by_zero = is_div && (b == '0);
        if (is_div) begin
            result = {(a_neg ? -mag_rem : mag_rem),
                      ((a_neg ^ b_neg) ? -mag_quot : mag_quot)};
        end else begin
            result = (a_neg ^ b_neg) ? -mag_prod : mag_prod;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: result is computed at issue, held in a
// pending register, and committed to HI/LO when the latency counter expires.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam int CNT_MAX = mdu_max(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] pending;
    logic               pending_wr;
    logic [2*WIDTH-1:0] arith_result;
    logic               arith_dz;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .a           (a),
        .b           (b),
        .op          (op),
        .result      (arith_result),
        .div_by_zero (arith_dz)
    );

    // A divide by zero still occupies the unit for the full latency, but its
    // commit is suppressed so HI/LO keep their previous contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= MDU_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            pending    <= '0;
            pending_wr <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                pending    <= arith_result;
                                pending_wr <= 1'b1;
                                cnt        <= MULT_LOAD;
                                busy       <= 1'b1;
                                state      <= MDU_BUSY;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                pending    <= arith_result;
                                pending_wr <= !arith_dz;
                                cnt        <= DIV_LOAD;
                                busy       <= 1'b1;
                                state      <= MDU_BUSY;
                            end
                            MDU_MTHI: hi <= a;
                            MDU_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MDU_BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        busy  <= 1'b0;
                        state <= MDU_IDLE;
                        if (pending_wr) begin
                            {hi, lo} <= pending;
                        end
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle corner sequences, and randomized ops against a reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [W-1:0] modelHi;
    logic [W-1:0] modelLo;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
        int           expCycles;
    } vector_t;

    vector_t vectors[$];

    mult_div_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural effect of one issued op on HI/LO.
    task automatic modelOp(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                           output int cycles);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        sa = ma;
        sb = mb;
        cycles = 0;
        case (mop)
            3'd0: begin
                sp = longint'(sa) * longint'(sb);
                modelHi = sp[63:32];
                modelLo = sp[31:0];
                cycles = 5;
            end
            3'd1: begin
                up = {32'd0, ma} * {32'd0, mb};
                modelHi = up[63:32];
                modelLo = up[31:0];
                cycles = 5;
            end
            3'd2: begin
                cycles = 10;
                if (mb != 0) begin
                    if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                        modelLo = 32'h8000_0000;
                        modelHi = 32'h0;
                    end else begin
                        modelLo = sa / sb;
                        modelHi = sa % sb;
                    end
                end
            end
            3'd3: begin
                cycles = 10;
                if (mb != 0) begin
                    modelLo = ma / mb;
                    modelHi = ma % mb;
                end
            end
            3'd4: modelHi = ma;
            3'd5: modelLo = ma;
            default: ;
        endcase
    endtask

    // Issue one op, scramble operands right after the sampling edge, then count
    // busy cycles while watching for a premature HI/LO change.
    task automatic applyStimulus(input logic [2:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb,
                                 output int cycles, output logic earlyChange);
        logic [W-1:0] preHi;
        logic [W-1:0] preLo;
        @(negedge clk);
        preHi = hi;
        preLo = lo;
        start = 1'b1;
        op    = sop;
        a     = sa;
        b     = sb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cycles = 0;
        earlyChange = 1'b0;
        @(negedge clk);
        while (busy && cycles < 200) begin
            cycles++;
            if (hi !== preHi || lo !== preLo) earlyChange = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   cyc;
        int   mcyc;
        logic early;
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vectors.push_back('{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 5});
        vectors.push_back('{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5});
        vectors.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        vectors.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10});
        vectors.push_back('{3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'h8000_0000, 0});
        vectors.push_back('{3'd5, 32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0});
        vectors.push_back('{3'd3, 32'd7,         32'd0,         32'h0000_1234, 32'h0000_5678, 10});
        vectors.push_back('{3'd6, 32'h0000_FFFF, 32'd3,         32'h0000_1234, 32'h0000_5678, 0});
        vectors.push_back('{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5});
        vectors.push_back('{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10});

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        a       = '0;
        b       = '0;
        modelHi = '0;
        modelLo = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);

        for (int i = 0; i < vectors.size(); i++) begin
            modelOp(vectors[i].op, vectors[i].a, vectors[i].b, mcyc);
            applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, cyc, early);
            checkOutput($sformatf("vec%0d_cycles", i), cyc, vectors[i].expCycles);
            checkOutput($sformatf("vec%0d_hold", i), {31'd0, early}, 32'd0);
            checkOutput($sformatf("vec%0d_hi", i), hi, vectors[i].expHi);
            checkOutput($sformatf("vec%0d_lo", i), lo, vectors[i].expLo);
        end

        // MTLO arriving while a MULT is in flight must be dropped.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        waitIdle(cyc);
        modelHi = 32'd0;
        modelLo = 32'd15;
        checkOutput("mid_mtlo_hi", hi, 32'd0);
        checkOutput("mid_mtlo_lo", lo, 32'd15);

        // Back-to-back: start held high is accepted the cycle after busy falls.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        @(negedge clk);
        waitIdle(cyc);
        checkOutput("b2b_first_cycles", cyc, 32'd5);
        checkOutput("b2b_first_lo", lo, 32'd6);
        op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        checkOutput("b2b_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        waitIdle(cyc);
        checkOutput("b2b_second_cycles", cyc, 32'd10);
        checkOutput("b2b_second_hi", hi, 32'd2);
        checkOutput("b2b_second_lo", lo, 32'd14);
        modelHi = 32'd2;
        modelLo = 32'd14;

        // Asynchronous reset in cycle 3 of a DIV aborts it and discards the result.
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_hi", hi, 32'd0);
        checkOutput("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("rst_after_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_after_hi", hi, 32'd0);
        checkOutput("rst_after_lo", lo, 32'd0);
        modelHi = '0;
        modelLo = '0;

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            modelOp(rop, ra, rb, mcyc);
            applyStimulus(rop, ra, rb, cyc, early);
            checkOutput($sformatf("rnd%0d_cycles", n), cyc, mcyc);
            checkOutput($sformatf("rnd%0d_hold", n), {31'd0, early}, 32'd0);
            checkOutput($sformatf("rnd%0d_hi", n), hi, modelHi);
            checkOutput($sformatf("rnd%0d_lo", n), lo, modelLo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
